// File: rtl/coco_ram_arbiter.sv
// rtl/coco_ram_arbiter.sv - single-port RAM arbiter for CPU, VDG fetch and ioctl loader
module coco_ram_arbiter #(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 8,
    parameter int                RAM_LAT = 1,
    parameter bit                WP_EN   = 1'b1,
    parameter logic [ADDR_W-1:0] WP_BASE = ADDR_W'(16'h8000)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic              o_vid_ack,
    output logic [DATA_W-1:0] o_vid_rdata,
    input  logic              i_ld_req,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_wdata,
    output logic              o_ld_ack,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {G_CPU, G_VID, G_LD} gnt_t;

    localparam logic [1:0] LAST_WAIT = (RAM_LAT > 1) ? 2'(RAM_LAT - 2) : 2'd0;

    state_t              r_state;
    gnt_t                r_gnt;
    logic                r_is_rd;
    logic                r_last_vid;
    logic [1:0]          r_cnt;
    logic                r_busy;
    logic                r_cpu_ack;
    logic                r_vid_ack;
    logic                r_ld_ack;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_vid_rdata;
    logic                r_ram_en;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;

    logic w_pick_ld;
    logic w_pick_vid;
    logic w_pick_cpu;
    logic w_cpu_wp;
    logic w_enter_done;

    // Loader always wins; VID/CPU tie goes to whichever was not granted last.
    assign w_pick_ld  = i_ld_req;
    assign w_pick_vid = !i_ld_req && i_vid_req && (!i_cpu_req || !r_last_vid);
    assign w_pick_cpu = !i_ld_req && i_cpu_req && (!i_vid_req || r_last_vid);
    assign w_cpu_wp   = WP_EN && (i_cpu_addr >= WP_BASE);

    assign w_enter_done = (r_state == S_ACCESS && (!r_is_rd || RAM_LAT == 1)) ||
                          (r_state == S_WAIT && r_cnt == LAST_WAIT);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_gnt       <= G_CPU;
            r_is_rd     <= 1'b0;
            r_last_vid  <= 1'b0;
            r_cnt       <= 2'd0;
            r_busy      <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_vid_ack   <= 1'b0;
            r_ld_ack    <= 1'b0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_vid_ack <= 1'b0;
            r_ld_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_ld || w_pick_vid || w_pick_cpu) begin
                        r_state  <= S_ACCESS;
                        r_busy   <= 1'b1;
                        r_ram_en <= 1'b1;
                        if (w_pick_ld) begin
                            r_gnt       <= G_LD;
                            r_is_rd     <= 1'b0;
                            r_ram_we    <= 1'b1;
                            r_ram_addr  <= i_ld_addr;
                            r_ram_wdata <= i_ld_wdata;
                        end else if (w_pick_vid) begin
                            r_gnt       <= G_VID;
                            r_is_rd     <= 1'b1;
                            r_ram_we    <= 1'b0;
                            r_ram_addr  <= i_vid_addr;
                            r_ram_wdata <= '0;
                            r_last_vid  <= 1'b1;
                        end else begin
                            // Protected CPU writes still run the full cycle, just without the strobe.
                            r_gnt       <= G_CPU;
                            r_is_rd     <= !i_cpu_we;
                            r_ram_we    <= i_cpu_we && !w_cpu_wp;
                            r_ram_addr  <= i_cpu_addr;
                            r_ram_wdata <= i_cpu_wdata;
                            r_last_vid  <= 1'b0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_ram_en <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_cnt    <= 2'd0;
                    r_state  <= w_enter_done ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (w_enter_done) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Ack and read data are launched on the same edge so rdata is valid in the ack cycle.
            if (w_enter_done) begin
                r_cpu_ack <= (r_gnt == G_CPU);
                r_vid_ack <= (r_gnt == G_VID);
                r_ld_ack  <= (r_gnt == G_LD);
                if (r_is_rd && r_gnt == G_CPU) begin
                    r_cpu_rdata <= i_ram_rdata;
                end
                if (r_is_rd && r_gnt == G_VID) begin
                    r_vid_rdata <= i_ram_rdata;
                end
            end
        end
    end

    assign o_cpu_ack   = r_cpu_ack;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_vid_ack   = r_vid_ack;
    assign o_vid_rdata = r_vid_rdata;
    assign o_ld_ack    = r_ld_ack;
    assign o_ram_en    = r_ram_en;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_coco_ram_arbiter.sv
// tb/tb_coco_ram_arbiter.sv - directed bench for coco_ram_arbiter at RAM_LAT 1, 2 and 3
module tb_coco_ram_arbiter;

    logic clk = 1'b0;
    logic rst;

    logic        cpu_req [3];
    logic        cpu_we [3];
    logic [15:0] cpu_addr [3];
    logic [7:0]  cpu_wdata [3];
    logic        cpu_ack [3];
    logic [7:0]  cpu_rdata [3];
    logic        vid_req [3];
    logic [15:0] vid_addr [3];
    logic        vid_ack [3];
    logic [7:0]  vid_rdata [3];
    logic        ld_req [3];
    logic [15:0] ld_addr [3];
    logic [7:0]  ld_wdata [3];
    logic        ld_ack [3];
    logic        ram_en [3];
    logic        ram_we [3];
    logic [15:0] ram_addr [3];
    logic [7:0]  ram_wdata [3];
    logic [7:0]  ram_rdata [3];
    logic        busy [3];

    logic [7:0]  mem [3][65536];
    logic [7:0]  d0 [3];
    logic [7:0]  p1 [3];
    logic [7:0]  p2 [3];
    int          we_cnt [3] = '{0, 0, 0};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        coco_ram_arbiter #(.RAM_LAT(g + 1)) u_dut (
            .i_clk(clk), .i_reset(rst),
            .i_cpu_req(cpu_req[g]), .i_cpu_we(cpu_we[g]), .i_cpu_addr(cpu_addr[g]),
            .i_cpu_wdata(cpu_wdata[g]), .o_cpu_ack(cpu_ack[g]), .o_cpu_rdata(cpu_rdata[g]),
            .i_vid_req(vid_req[g]), .i_vid_addr(vid_addr[g]), .o_vid_ack(vid_ack[g]),
            .o_vid_rdata(vid_rdata[g]),
            .i_ld_req(ld_req[g]), .i_ld_addr(ld_addr[g]), .i_ld_wdata(ld_wdata[g]),
            .o_ld_ack(ld_ack[g]),
            .o_ram_en(ram_en[g]), .o_ram_we(ram_we[g]), .o_ram_addr(ram_addr[g]),
            .o_ram_wdata(ram_wdata[g]), .i_ram_rdata(ram_rdata[g]), .o_busy(busy[g])
        );
    end

    // RAM models: data for a read strobe appears k register stages later (k=0 is combinational).
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            d0[k] = (ram_en[k] && !ram_we[k]) ? mem[k][ram_addr[k]] : 8'hEE;
            ram_rdata[k] = (k == 0) ? d0[k] : (k == 1) ? p1[k] : p2[k];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ram_en[k] && ram_we[k]) begin
                mem[k][ram_addr[k]] <= ram_wdata[k];
                we_cnt[k] <= we_cnt[k] + 1;
            end
            p1[k] <= d0[k];
            p2[k] <= p1[k];
        end
    end

    function automatic logic ack_of(input int k, input int port);
        return (port == 0) ? cpu_ack[k] : (port == 1) ? vid_ack[k] : ld_ack[k];
    endfunction

    task automatic access(input int k, input int port, input logic we, input logic [15:0] addr,
                          input logic [7:0] wd, output int lat, output logic [7:0] rd);
        int n;
        case (port)
            0: begin cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wd; cpu_req[k] = 1'b1; end
            1: begin vid_addr[k] = addr; vid_req[k] = 1'b1; end
            default: begin ld_addr[k] = addr; ld_wdata[k] = wd; ld_req[k] = 1'b1; end
        endcase
        lat = -1;
        rd  = 8'h00;
        n   = 0;
        while (lat < 0 && n < 20) begin
            n++;
            @(posedge clk); #1;
            if (ack_of(k, port)) begin
                lat = n;
                rd  = (port == 0) ? cpu_rdata[k] : vid_rdata[k];
            end
        end
        cpu_req[k] = 1'b0;
        vid_req[k] = 1'b0;
        ld_req[k]  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({ram_en[k], ram_we[k], busy[k]} !== 3'b000) begin
                n_bad++; $display("FAIL reset_ctrl k=%0d: got %b expected 000", k, {ram_en[k], ram_we[k], busy[k]});
            end
            n_cmp++;
            if ({cpu_ack[k], vid_ack[k], ld_ack[k]} !== 3'b000) begin
                n_bad++; $display("FAIL reset_acks k=%0d: got %b expected 000", k, {cpu_ack[k], vid_ack[k], ld_ack[k]});
            end
            n_cmp++;
            if ({cpu_rdata[k], vid_rdata[k], ram_addr[k], ram_wdata[k]} !== 40'h0) begin
                n_bad++; $display("FAIL reset_data k=%0d: got %h expected 0", k, {cpu_rdata[k], vid_rdata[k], ram_addr[k], ram_wdata[k]});
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_rw();
        int lat;
        logic [7:0] rd;
        for (int k = 0; k < 3; k++) begin
            access(k, 0, 1'b1, 16'h1234, 8'h5A, lat, rd);
            n_cmp++;
            if (lat !== 2) begin n_bad++; $display("FAIL cpu_wr_lat k=%0d: got %0d expected 2", k, lat); end
            access(k, 0, 1'b0, 16'h1234, 8'h00, lat, rd);
            n_cmp++;
            if (lat !== k + 2) begin n_bad++; $display("FAIL cpu_rd_lat k=%0d: got %0d expected %0d", k, lat, k + 2); end
            n_cmp++;
            if (rd !== 8'h5A) begin n_bad++; $display("FAIL cpu_rd_data k=%0d: got %h expected 5a", k, rd); end
            access(k, 0, 1'b1, 16'h1235, 8'hC3, lat, rd);
            n_cmp++;
            if (cpu_rdata[k] !== 8'h5A) begin n_bad++; $display("FAIL cpu_rd_hold k=%0d: got %h expected 5a", k, cpu_rdata[k]); end
        end
    endtask

    task automatic test_round_robin();
        int nv, nc, idx, last, cyc, got, expv;
        for (int k = 0; k < 3; k++) begin
            vid_addr[k] = 16'h1234;
            cpu_we[k] = 1'b0; cpu_addr[k] = 16'h1235;
            vid_req[k] = 1'b1; cpu_req[k] = 1'b1;
            nv = 0; nc = 0; idx = 0; last = -1; cyc = 0;
            while ((nv < 4 || nc < 4) && cyc < 200) begin
                cyc++;
                @(posedge clk); #1;
                if (vid_ack[k] || cpu_ack[k]) begin
                    got  = vid_ack[k] ? 1 : 0;
                    expv = (idx % 2 == 0) ? 1 : 0;
                    n_cmp++;
                    if (got !== expv) begin n_bad++; $display("FAIL rr_order k=%0d idx=%0d: got vid=%0d expected vid=%0d", k, idx, got, expv); end
                    if (last >= 0) begin
                        n_cmp++;
                        if (cyc - last !== k + 3) begin n_bad++; $display("FAIL rr_spacing k=%0d: got %0d expected %0d", k, cyc - last, k + 3); end
                    end
                    last = cyc;
                    idx++;
                    if (vid_ack[k]) begin
                        n_cmp++;
                        if (vid_rdata[k] !== 8'h5A) begin n_bad++; $display("FAIL rr_vid_data k=%0d: got %h expected 5a", k, vid_rdata[k]); end
                        nv++;
                        if (nv == 4) vid_req[k] = 1'b0;
                    end
                    if (cpu_ack[k]) begin
                        n_cmp++;
                        if (cpu_rdata[k] !== 8'hC3) begin n_bad++; $display("FAIL rr_cpu_data k=%0d: got %h expected c3", k, cpu_rdata[k]); end
                        nc++;
                        if (nc == 4) cpu_req[k] = 1'b0;
                    end
                end
            end
            n_cmp++;
            if (nv * 10 + nc !== 44) begin n_bad++; $display("FAIL rr_count k=%0d: got vid=%0d cpu=%0d expected 4/4", k, nv, nc); end
            vid_req[k] = 1'b0; cpu_req[k] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_loader_priority();
        int nld, early, last, cyc, wc, wprev, first_after;
        int lat;
        logic [7:0] rd;
        for (int k = 0; k < 3; k++) begin
            ld_addr[k] = 16'h0000; ld_wdata[k] = 8'hA5; ld_req[k] = 1'b1;
            vid_addr[k] = 16'h1234; vid_req[k] = 1'b1;
            cpu_we[k] = 1'b0; cpu_addr[k] = 16'h1235; cpu_req[k] = 1'b1;
            wc = we_cnt[k]; wprev = wc;
            nld = 0; early = 0; last = 0; cyc = 0; first_after = -1;
            while ((nld < 256 || vid_req[k] || cpu_req[k]) && cyc < 2000) begin
                cyc++;
                @(posedge clk); #1;
                if (ld_ack[k]) begin
                    n_cmp++;
                    if (cyc - last !== ((nld == 0) ? 2 : 3)) begin n_bad++; $display("FAIL ld_slot k=%0d n=%0d: got %0d expected %0d", k, nld, cyc - last, (nld == 0) ? 2 : 3); end
                    n_cmp++;
                    if (we_cnt[k] - wprev !== 1) begin n_bad++; $display("FAIL ld_we k=%0d n=%0d: got %0d strobes expected 1", k, nld, we_cnt[k] - wprev); end
                    wprev = we_cnt[k];
                    last = cyc;
                    nld++;
                    if (nld == 256) ld_req[k] = 1'b0;
                    else begin ld_addr[k] = 16'(nld); ld_wdata[k] = 8'(nld) ^ 8'hA5; end
                end
                if (vid_ack[k] || cpu_ack[k]) begin
                    if (nld < 256) early++;
                    if (first_after < 0) first_after = vid_ack[k] ? 1 : 0;
                    if (vid_ack[k]) vid_req[k] = 1'b0;
                    if (cpu_ack[k]) cpu_req[k] = 1'b0;
                end
            end
            n_cmp++;
            if (early !== 0 || nld !== 256) begin n_bad++; $display("FAIL ld_priority k=%0d: got early=%0d loads=%0d expected 0/256", k, early, nld); end
            n_cmp++;
            if (first_after !== 1) begin n_bad++; $display("FAIL ld_then_vid k=%0d: got vid=%0d expected 1", k, first_after); end
            n_cmp++;
            if (we_cnt[k] - wc !== 256) begin n_bad++; $display("FAIL ld_we_total k=%0d: got %0d expected 256", k, we_cnt[k] - wc); end
            ld_req[k] = 1'b0; vid_req[k] = 1'b0; cpu_req[k] = 1'b0;
            @(posedge clk); #1;
            access(k, 0, 1'b0, 16'h0000, 8'h00, lat, rd);
            n_cmp++;
            if (rd !== 8'hA5) begin n_bad++; $display("FAIL ld_rb0 k=%0d: got %h expected a5", k, rd); end
            access(k, 0, 1'b0, 16'h007F, 8'h00, lat, rd);
            n_cmp++;
            if (rd !== 8'hDA) begin n_bad++; $display("FAIL ld_rb7f k=%0d: got %h expected da", k, rd); end
            access(k, 1, 1'b0, 16'h00FF, 8'h00, lat, rd);
            n_cmp++;
            if (rd !== 8'h5A) begin n_bad++; $display("FAIL ld_rbff k=%0d: got %h expected 5a", k, rd); end
        end
    endtask

    task automatic test_write_protect();
        int lat, wc;
        logic [7:0] rd;
        for (int k = 0; k < 3; k++) begin
            wc = we_cnt[k];
            access(k, 0, 1'b1, 16'hA000, 8'h77, lat, rd);
            n_cmp++;
            if (lat !== 2) begin n_bad++; $display("FAIL wp_ack k=%0d: got lat %0d expected 2", k, lat); end
            n_cmp++;
            if (we_cnt[k] !== wc) begin n_bad++; $display("FAIL wp_no_we k=%0d: got %0d strobes expected 0", k, we_cnt[k] - wc); end
            access(k, 2, 1'b1, 16'hA000, 8'h3C, lat, rd);
            access(k, 0, 1'b1, 16'hA000, 8'h77, lat, rd);
            access(k, 0, 1'b0, 16'hA000, 8'h00, lat, rd);
            n_cmp++;
            if (rd !== 8'h3C) begin n_bad++; $display("FAIL wp_intact k=%0d: got %h expected 3c", k, rd); end
            access(k, 2, 1'b1, 16'h8000, 8'h99, lat, rd);
            access(k, 0, 1'b1, 16'h8000, 8'h22, lat, rd);
            access(k, 0, 1'b0, 16'h8000, 8'h00, lat, rd);
            n_cmp++;
            if (rd !== 8'h99) begin n_bad++; $display("FAIL wp_base k=%0d: got %h expected 99", k, rd); end
            wc = we_cnt[k];
            access(k, 0, 1'b1, 16'h7FFF, 8'h11, lat, rd);
            access(k, 0, 1'b0, 16'h7FFF, 8'h00, lat, rd);
            n_cmp++;
            if (rd !== 8'h11 || we_cnt[k] - wc !== 1) begin n_bad++; $display("FAIL wp_below k=%0d: got %h/%0d expected 11/1", k, rd, we_cnt[k] - wc); end
        end
    endtask

    task automatic test_reset_wait();
        int cyc, acks, first;
        vid_addr[2] = 16'h1234; vid_req[2] = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (ram_en[2] !== 1'b1) begin n_bad++; $display("FAIL rw_access: got ram_en %b expected 1", ram_en[2]); end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy[2], ram_en[2]} !== 2'b10) begin n_bad++; $display("FAIL rw_in_wait: got %b expected 10", {busy[2], ram_en[2]}); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy[2], ram_en[2], vid_ack[2], cpu_ack[2], ld_ack[2]} !== 5'b0) begin
            n_bad++; $display("FAIL rw_async: got %b expected 00000", {busy[2], ram_en[2], vid_ack[2], cpu_ack[2], ld_ack[2]});
        end
        vid_req[2] = 1'b0;
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (vid_ack[2] || cpu_ack[2] || ram_en[2]) acks++;
        end
        n_cmp++;
        if (acks !== 0) begin n_bad++; $display("FAIL rw_no_ack: got %0d active cycles expected 0", acks); end
        rst = 1'b0;
        @(posedge clk); #1;
        vid_req[2] = 1'b1; cpu_we[2] = 1'b0; cpu_addr[2] = 16'h1235; cpu_req[2] = 1'b1;
        first = -1; cyc = 0;
        while (first < 0 && cyc < 20) begin
            cyc++;
            @(posedge clk); #1;
            if (vid_ack[2] || cpu_ack[2]) first = vid_ack[2] ? 1 : 0;
        end
        n_cmp++;
        if (first !== 1) begin n_bad++; $display("FAIL rw_tie_vid: got vid=%0d expected 1", first); end
        n_cmp++;
        if (cyc !== 4) begin n_bad++; $display("FAIL rw_tie_lat: got %0d expected 4", cyc); end
        vid_req[2] = 1'b0; cpu_req[2] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_lat_sweep();
        int n, last, cyc;
        for (int k = 0; k < 3; k++) begin
            cpu_we[k] = 1'b0; cpu_addr[k] = 16'h1234; cpu_req[k] = 1'b1;
            n = 0; last = 0; cyc = 0;
            while (n < 3 && cyc < 50) begin
                cyc++;
                @(posedge clk); #1;
                if (cpu_ack[k]) begin
                    n_cmp++;
                    if (cyc - last !== ((n == 0) ? k + 2 : k + 3)) begin
                        n_bad++; $display("FAIL sweep_spacing k=%0d n=%0d: got %0d expected %0d", k, n, cyc - last, (n == 0) ? k + 2 : k + 3);
                    end
                    n_cmp++;
                    if (cpu_rdata[k] !== 8'h5A) begin n_bad++; $display("FAIL sweep_data k=%0d: got %h expected 5a", k, cpu_rdata[k]); end
                    last = cyc;
                    n++;
                    if (n == 3) cpu_req[k] = 1'b0;
                end
            end
            n_cmp++;
            if (n !== 3) begin n_bad++; $display("FAIL sweep_count k=%0d: got %0d expected 3", k, n); end
            cpu_req[k] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = 16'h0; cpu_wdata[k] = 8'h0;
            vid_req[k] = 1'b0; vid_addr[k] = 16'h0;
            ld_req[k] = 1'b0; ld_addr[k] = 16'h0; ld_wdata[k] = 8'h0;
        end
        test_reset();
        test_cpu_rw();
        test_round_robin();
        test_loader_priority();
        test_write_protect();
        test_reset_wait();
        test_lat_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
